// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern encodings and the colour-bar table for the
// PAL-style test pattern generator.
package video_timing_pkg;

  localparam int PAL_PIX_DIV      = 2;
  localparam int PAL_H_TOTAL      = 384;
  localparam int PAL_H_ACTIVE     = 320;
  localparam int PAL_H_SYNC_START = 336;
  localparam int PAL_H_SYNC_LEN   = 28;
  localparam int PAL_V_TOTAL      = 312;
  localparam int PAL_V_ACTIVE     = 256;
  localparam int PAL_V_SYNC_START = 280;
  localparam int PAL_V_SYNC_LEN   = 3;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'b00,
    PAT_GRID     = 2'b01,
    PAT_GRADIENT = 2'b10,
    PAT_SOLID    = 2'b11
  } pattern_e;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_t;

  localparam logic [5:0] FULL = 6'h3F;
  localparam logic [5:0] NONE = 6'h00;

  // Classic 75%-order bars, left to right, at full scale.
  localparam rgb_t BAR_COLOURS [8] = '{
    '{FULL, FULL, FULL},  // white
    '{FULL, FULL, NONE},  // yellow
    '{NONE, FULL, FULL},  // cyan
    '{NONE, FULL, NONE},  // green
    '{FULL, NONE, FULL},  // magenta
    '{FULL, NONE, NONE},  // red
    '{NONE, NONE, FULL},  // blue
    '{NONE, NONE, NONE}   // black
  };

endpackage

// File: rtl/tpg_bar_lut.sv
// Combinational colour-bar lookup: 3-bit bar index to 18-bit RGB.
module tpg_bar_lut
  import video_timing_pkg::*;
(
  input  logic [2:0] bar_idx,
  output rgb_t       rgb
);

  assign rgb = BAR_COLOURS[bar_idx];

endmodule

// File: rtl/pal_test_pattern_gen.sv
// 15 kHz PAL-style raster timing and test-pattern source: pixel divider,
// h/v/frame counters, sync/blank decode, pattern mux and registered outputs.
module pal_test_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int PIX_DIV      = PAL_PIX_DIV,
  parameter int H_TOTAL      = PAL_H_TOTAL,
  parameter int H_ACTIVE     = PAL_H_ACTIVE,
  parameter int H_SYNC_START = PAL_H_SYNC_START,
  parameter int H_SYNC_LEN   = PAL_H_SYNC_LEN,
  parameter int V_TOTAL      = PAL_V_TOTAL,
  parameter int V_ACTIVE     = PAL_V_ACTIVE,
  parameter int V_SYNC_START = PAL_V_SYNC_START,
  parameter int V_SYNC_LEN   = PAL_V_SYNC_LEN
)(
  input  logic       clkvideo,
  input  logic       rst,
  input  logic [1:0] pattern_sel,
  output logic [5:0] r,
  output logic [5:0] g,
  output logic [5:0] b,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       csync_n,
  output logic       blank,
  output logic       frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             pe;
  logic [9:0]       h, v;
  logic [5:0]       frame_cnt;
  pattern_e         pat_q, pat_eff;
  logic             h_last, v_last, at_origin;
  logic             hs, vs, act_blank;
  logic [9:0]       bar_q;
  logic [2:0]       bar_idx;
  rgb_t             bar_rgb, pix;

  // With PIX_DIV=1 the counter sits at 0 and pe stays high every cycle.
  assign pe = (div_cnt == DIV_W'(PIX_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst)     div_cnt <= '0;
    else if (pe) div_cnt <= '0;
    else         div_cnt <= div_cnt + DIV_W'(1);
  end

  assign h_last    = (h == 10'(H_TOTAL - 1));
  assign v_last    = (v == 10'(V_TOTAL - 1));
  assign at_origin = (h == 10'd0) && (v == 10'd0);

  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (pe) begin
      h <= h_last ? 10'd0 : h + 10'd1;
      if (h_last) begin
        v <= v_last ? 10'd0 : v + 10'd1;
        if (v_last) frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // The selection is captured at the frame origin; that first pixel already
  // uses the new selection so a whole frame is drawn with one pattern.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst)                  pat_q <= PAT_BARS;
    else if (pe && at_origin) pat_q <= pattern_e'(pattern_sel);
  end

  assign pat_eff = at_origin ? pattern_e'(pattern_sel) : pat_q;

  assign hs = (h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_START + H_SYNC_LEN));
  assign vs = (v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_START + V_SYNC_LEN));
  assign act_blank = (h >= 10'(H_ACTIVE)) || (v >= 10'(V_ACTIVE));

  assign bar_q   = h / 10'(BAR_W);
  assign bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];

  tpg_bar_lut u_bar_lut (
    .bar_idx (bar_idx),
    .rgb     (bar_rgb)
  );

  // NOTE: pix gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pix = '{r: NONE, g: NONE, b: NONE};
    case (pat_eff)
      PAT_BARS: pix = bar_rgb;
      PAT_GRID: begin
        if ((h[3:0] == 4'd0) || (v[3:0] == 4'd0) ||
            (h == 10'(H_ACTIVE - 1)) || (v == 10'(V_ACTIVE - 1)))
          pix = '{r: FULL, g: FULL, b: FULL};
      end
      PAT_GRADIENT: pix = '{r: h[5:0], g: v[5:0], b: frame_cnt};
      PAT_SOLID:    pix = '{r: FULL, g: FULL, b: FULL};
      default:      pix = '{r: NONE, g: NONE, b: NONE};
    endcase
    if (act_blank) pix = '{r: NONE, g: NONE, b: NONE};
  end

  // Outputs describe the (h,v) seen on the previous pe.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) begin
      r       <= '0;
      g       <= '0;
      b       <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      csync_n <= 1'b1;
      blank   <= 1'b1;
    end else if (pe) begin
      r       <= pix.r;
      g       <= pix.g;
      b       <= pix.b;
      hsync_n <= ~hs;
      vsync_n <= ~vs;
      csync_n <= ~(hs ^ vs);
      blank   <= act_blank;
    end
  end

  // Single-clkvideo marker on the cycle the origin pixel appears.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= pe && at_origin;
  end

endmodule

// File: tb/tb_pal_test_pattern_gen.sv
// Directed bench for pal_test_pattern_gen on a reduced raster so many frames
// fit in a short run; expected pixels are queued ahead and compared on arrival.
module tb_pal_test_pattern_gen;

  localparam int PD  = 2;
  localparam int HT  = 24;
  localparam int HA  = 16;
  localparam int HSS = 18;
  localparam int HSL = 3;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int VSS = 9;
  localparam int VSL = 2;
  localparam int FP  = HT * VT;   // pixels per frame
  localparam int FC  = FP * PD;   // clkvideo cycles per frame

  logic       clkvideo;
  logic       rst;
  logic [1:0] pattern_sel;
  logic [5:0] r, g, b;
  logic       hsync_n, vsync_n, csync_n, blank, frame_start;

  pal_test_pattern_gen #(
    .PIX_DIV      (PD),
    .H_TOTAL      (HT),
    .H_ACTIVE     (HA),
    .H_SYNC_START (HSS),
    .H_SYNC_LEN   (HSL),
    .V_TOTAL      (VT),
    .V_ACTIVE     (VA),
    .V_SYNC_START (VSS),
    .V_SYNC_LEN   (VSL)
  ) dut (
    .clkvideo    (clkvideo),
    .rst         (rst),
    .pattern_sel (pattern_sel),
    .r           (r),
    .g           (g),
    .b           (b),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .csync_n     (csync_n),
    .blank       (blank),
    .frame_start (frame_start)
  );

  initial clkvideo = 1'b0;
  always #5 clkvideo = ~clkvideo;

  // Rising edges since the last reset release.
  int cyc;
  always @(posedge clkvideo or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    int          due;
    logic [22:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  localparam logic [22:0] RST_OUT = {18'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  function automatic logic [22:0] pack_exp(int rr, int gg, int bb, bit hn, bit vn,
                                           bit cn, bit bl, bit fs);
    return {6'(rr), 6'(gg), 6'(bb), hn, vn, cn, bl, fs};
  endfunction

  function automatic logic [22:0] observed();
    return {r, g, b, hsync_n, vsync_n, csync_n, blank, frame_start};
  endfunction

  // Expected outputs for linear pixel p since reset under pattern pat.
  function automatic logic [22:0] model(int p, int pat);
    int h, v, f, bi, rr, gg, bb;
    bit hs, vs, bl, fs;
    h  = p % HT;
    v  = (p / HT) % VT;
    f  = (p / FP) % 64;
    hs = (h >= HSS) && (h < HSS + HSL);
    vs = (v >= VSS) && (v < VSS + VSL);
    bl = (h >= HA) || (v >= VA);
    fs = (h == 0) && (v == 0);
    rr = 0; gg = 0; bb = 0;
    if (!bl) begin
      case (pat)
        0: begin
          bi = h / (HA / 8);
          if (bi > 7) bi = 7;
          rr = (bi == 0 || bi == 1 || bi == 4 || bi == 5) ? 63 : 0;
          gg = (bi <= 3) ? 63 : 0;
          bb = (bi == 0 || bi == 2 || bi == 4 || bi == 6) ? 63 : 0;
        end
        1: begin
          if ((h % 16 == 0) || (v % 16 == 0) || (h == HA - 1) || (v == VA - 1)) begin
            rr = 63; gg = 63; bb = 63;
          end
        end
        2: begin rr = h % 64; gg = v % 64; bb = f; end
        default: begin rr = 63; gg = 63; bb = 63; end
      endcase
    end
    return pack_exp(rr, gg, bb, !hs, !vs, !(hs ^ vs), bl, fs);
  endfunction

  function automatic int due_of(int p);
    return PD * (p + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int p, input logic [22:0] e);
    sb_t it;
    it.tag = tag;
    it.due = due_of(p);
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic push_px(input int p, input int pat);
    push_exp($sformatf("px_f%0d_v%0d_h%0d", p / FP, (p / HT) % VT, p % HT), p, model(p, pat));
  endtask

  // Advance to the next falling edge and retire every scoreboard entry now due.
  task automatic tick();
    sb_t it;
    @(negedge clkvideo);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      check({it.tag, "_slot"}, 32'(cyc), 32'(it.due));
      if (it.due == cyc) check(it.tag, 32'(observed()), 32'(it.exp));
    end
  endtask

  task automatic run_to(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 100000) begin
      tick();
      guard++;
    end
    check("run_to", 32'(cyc), 32'(c));
  endtask

  initial begin
    int  first_fall, second_fall, falls, fs_cnt, low_line0, guard, t0, rst_p;
    logic prev_hs;

    rst         = 1'b1;
    pattern_sel = 2'b00;

    // Frame 0: bars, with hand-derived anchor pixels on line 2.
    for (int p = 0; p < FP; p++) begin
      if (p == 0)           push_exp("first_px",  p, pack_exp(63, 63, 63, 1, 1, 1, 0, 1));
      if (p == 2 * HT + 0)  push_exp("bars_h0",   p, pack_exp(63, 63, 63, 1, 1, 1, 0, 0));
      if (p == 2 * HT + 2)  push_exp("bars_h2",   p, pack_exp(63, 63,  0, 1, 1, 1, 0, 0));
      if (p == 2 * HT + 14) push_exp("bars_h14",  p, pack_exp( 0,  0,  0, 1, 1, 1, 0, 0));
      if (p == 2 * HT + 16) push_exp("bars_blank", p, pack_exp(0,  0,  0, 1, 1, 1, 1, 0));
      push_px(p, 0);
    end
    // Frame 1: selection changes mid-frame, bars must persist.
    for (int p = FP; p < 2 * FP; p++) push_px(p, 0);
    // Frame 2: solid white from its very first pixel.
    push_exp("solid_first", 2 * FP, pack_exp(63, 63, 63, 1, 1, 1, 0, 1));
    for (int p = 2 * FP; p < 3 * FP; p++) push_px(p, 3);
    // Frame 3: grid.
    for (int p = 3 * FP; p < 4 * FP; p++) push_px(p, 1);
    // Frame 5: gradient line 3.
    for (int hh = 0; hh < HT; hh++) begin
      if (hh == 10) push_exp("grad_f5", 5 * FP + 3 * HT + hh, pack_exp(10, 3, 5, 1, 1, 1, 0, 0));
      push_px(5 * FP + 3 * HT + hh, 2);
    end
    push_exp("grad_f63",  63 * FP + 3 * HT + 10, pack_exp(10, 3, 63, 1, 1, 1, 0, 0));
    push_exp("grad_wrap", 64 * FP + 3 * HT + 10, pack_exp(10, 3,  0, 1, 1, 1, 0, 0));
    rst_p = 64 * FP + 9 * HT + 19;
    push_exp("pre_rst", rst_p, pack_exp(0, 0, 0, 0, 0, 1, 1, 0));

    repeat (3) @(negedge clkvideo);
    check("reset_state", 32'(observed()), 32'(RST_OUT));
    rst = 1'b0;

    tick();
    check("pre_pe_hold", 32'(observed()), 32'(RST_OUT));

    // Frame 0 timing: hsync pulses, line length, frame_start count.
    first_fall = -1; second_fall = -1; falls = 0; fs_cnt = 0; low_line0 = 0;
    prev_hs = hsync_n;
    guard = 0;
    while (cyc < FC + 1 && guard < 2 * FC) begin
      tick();
      guard++;
      if (frame_start) fs_cnt++;
      if (!hsync_n && cyc < 2 + HT * PD) low_line0++;
      if (prev_hs && !hsync_n) begin
        falls++;
        if (first_fall < 0)       first_fall  = cyc;
        else if (second_fall < 0) second_fall = cyc;
      end
      prev_hs = hsync_n;
    end
    check("hs_first_fall",   32'(first_fall), 32'(PD * (HSS + 1)));
    check("hs_low_width",    32'(low_line0),  32'(HSL * PD));
    check("line_cycles",     32'(second_fall - first_fall), 32'(HT * PD));
    check("hs_pulses_frame", 32'(falls),      32'(VT));
    check("fs_per_frame",    32'(fs_cnt),     32'd1);

    run_to(due_of(FP + 4 * HT));
    pattern_sel = 2'b11;
    run_to(due_of(2 * FP + 4 * HT));
    pattern_sel = 2'b01;
    run_to(due_of(3 * FP + 4 * HT));
    pattern_sel = 2'b10;

    // Reset in the middle of a sync-active pixel, checked before any clock edge.
    run_to(due_of(rst_p));
    check("sb_drained", 32'(sb.size()), 32'd0);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(observed()), 32'(RST_OUT));
    repeat (2) @(negedge clkvideo);
    rst = 1'b0;

    push_exp("grad_after_rst", 3 * HT + 10, pack_exp(10, 3, 0, 1, 1, 1, 0, 0));
    guard = 0;
    while (!frame_start && guard < 10) begin
      tick();
      guard++;
    end
    check("fs_after_rst", 32'(cyc), 32'(PD));
    t0 = cyc;
    tick();
    guard = 0;
    while (!frame_start && guard < 2 * FC) begin
      tick();
      guard++;
    end
    check("frame_period", 32'(cyc - t0), 32'(FC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
